// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result bus for the registered sequential ALU.
// The master side (operand registers / control unit) drives the request.
// The slave side (the ALU) returns status, result and flags.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero_flag;
    logic             carry_flag;
    logic             negative_flag;
    logic             overflow_flag;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, result, result_hi,
        input  zero_flag, carry_flag, negative_flag, overflow_flag
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, result, result_hi,
        output zero_flag, carry_flag, negative_flag, overflow_flag
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: parametrised registered ALU with a start/done handshake.
// Single-cycle arithmetic, logic, shift and rotate ops complete with
// latency 1. Z/C/N/V flags are persistent and change only on done.
// Build option ALU_MUL_EN: opcode E runs a WIDTH-cycle shift-add multiply.
// Without ALU_MUL_EN, opcode E returns zero in one cycle and keeps the flags.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    alu_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_ADC  = 4'h6;
    localparam logic [3:0] OP_SBC  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ROL  = 4'hA;
    localparam logic [3:0] OP_ROR  = 4'hB;
    localparam logic [3:0] OP_INC  = 4'hC;
    localparam logic [3:0] OP_DEC  = 4'hD;
    localparam logic [3:0] OP_MUL  = 4'hE;
    localparam logic [3:0] OP_PASS = 4'hF;

    typedef enum logic {
        IDLE,
        MUL_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] resultHi_q, resultHi_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    logic [WIDTH-1:0] aluRes;
    logic             aluC;
    logic             aluV;
    logic [WIDTH:0]   aExt;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   addCarry;
    logic [WIDTH:0]   subtrahend;
    logic [WIDTH:0]   subBorrow;
    logic [WIDTH:0]   sumExt;
    logic [WIDTH:0]   diffExt;
    logic             addV;
    logic             subV;

    // Single-cycle datapath: one shared adder and one shared subtractor in
    // WIDTH+1 bits, with the operand/carry muxes picking ADD/ADC/INC and
    // SUB/SBC/DEC; the registered carry feeds ADC/SBC chaining.
    always_comb begin
        aExt       = {1'b0, bus.a_in};
        addend     = (bus.op == OP_INC) ? {{WIDTH{1'b0}}, 1'b1} : {1'b0, bus.b_in};
        addCarry   = (bus.op == OP_ADC) ? {{WIDTH{1'b0}}, carry_q} : '0;
        subtrahend = (bus.op == OP_DEC) ? {{WIDTH{1'b0}}, 1'b1} : {1'b0, bus.b_in};
        subBorrow  = (bus.op == OP_SBC) ? {{WIDTH{1'b0}}, ~carry_q} : '0;
        sumExt     = aExt + addend + addCarry;
        diffExt    = aExt - subtrahend - subBorrow;
        addV       = (bus.a_in[WIDTH-1] == addend[WIDTH-1]) &&
                     (sumExt[WIDTH-1] != bus.a_in[WIDTH-1]);
        subV       = (bus.a_in[WIDTH-1] != subtrahend[WIDTH-1]) &&
                     (diffExt[WIDTH-1] != bus.a_in[WIDTH-1]);
        aluRes     = '0;
        aluC       = 1'b0;
        aluV       = 1'b0;
        case (bus.op)
            OP_ADD, OP_ADC, OP_INC: begin
                aluRes = sumExt[WIDTH-1:0];
                aluC   = sumExt[WIDTH];
                aluV   = addV;
            end
            OP_SUB, OP_SBC: begin
                aluRes = diffExt[WIDTH-1:0];
                aluC   = ~diffExt[WIDTH];
                aluV   = subV;
            end
            OP_DEC: begin
                aluRes = diffExt[WIDTH-1:0];
                aluC   = diffExt[WIDTH];
                aluV   = subV;
            end
            OP_AND:  aluRes = bus.a_in & bus.b_in;
            OP_OR:   aluRes = bus.a_in | bus.b_in;
            OP_XOR:  aluRes = bus.a_in ^ bus.b_in;
            OP_NOT:  aluRes = ~bus.a_in;
            OP_PASS: aluRes = bus.a_in;
            OP_SHL: begin
                aluRes = {bus.a_in[WIDTH-2:0], 1'b0};
                aluC   = bus.a_in[WIDTH-1];
            end
            OP_SHR: begin
                aluRes = {1'b0, bus.a_in[WIDTH-1:1]};
                aluC   = bus.a_in[0];
            end
            OP_ROL: begin
                aluRes = {bus.a_in[WIDTH-2:0], bus.a_in[WIDTH-1]};
                aluC   = bus.a_in[WIDTH-1];
            end
            OP_ROR: begin
                aluRes = {bus.a_in[0], bus.a_in[WIDTH-1:1]};
                aluC   = bus.a_in[0];
            end
            default: begin
                aluRes = '0;
                aluC   = 1'b0;
                aluV   = 1'b0;
            end
        endcase
    end

    // Next-state logic: accept a request only in IDLE, register the result
    // and flags together with the done pulse, and step the multiplier one
    // multiplier bit per cycle while in MUL_RUN.
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        resultHi_d = resultHi_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
`ifdef ALU_MUL_EN
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_MUL) begin
`ifdef ALU_MUL_EN
                        state_d  = MUL_RUN;
                        mcand_d  = {{WIDTH{1'b0}}, bus.a_in};
                        mplier_d = bus.b_in;
                        acc_d    = '0;
                        cnt_d    = '0;
`else
                        done_d     = 1'b1;
                        result_d   = '0;
                        resultHi_d = '0;
`endif
                    end else begin
                        done_d     = 1'b1;
                        result_d   = aluRes;
                        resultHi_d = '0;
                        zero_d     = (aluRes == '0);
                        carry_d    = aluC;
                        neg_d      = aluRes[WIDTH-1];
                        ovf_d      = aluV;
                    end
                end
            end
            MUL_RUN: begin
`ifdef ALU_MUL_EN
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    result_d   = acc_d[WIDTH-1:0];
                    resultHi_d = acc_d[2*WIDTH-1:WIDTH];
                    zero_d     = (acc_d == '0);
                    carry_d    = |acc_d[2*WIDTH-1:WIDTH];
                    neg_d      = acc_d[2*WIDTH-1];
                    ovf_d      = 1'b0;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State, result, flag and multiplier registers; reset aborts any
    // multiply in flight and clears every visible output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            result_q   <= '0;
            resultHi_q <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q    <= '0;
            acc_q      <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            resultHi_q <= resultHi_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
`ifdef ALU_MUL_EN
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign bus.busy          = (state_q == MUL_RUN);
    assign bus.done          = done_q;
    assign bus.result        = result_q;
    assign bus.result_hi     = resultHi_q;
    assign bus.zero_flag     = zero_q;
    assign bus.carry_flag    = carry_q;
    assign bus.negative_flag = neg_q;
    assign bus.overflow_flag = ovf_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=8).
// A cycle model built from plain integer arithmetic predicts every output
// and is compared on each falling edge; directed vectors also carry
// hand-computed literal results and flags.
module tb_alu_seq;
    localparam int W = 8;
    localparam int M = 1 << W;

    logic clk = 1'b0;
    logic reset_n;
    bit   cmpEn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus();

    alu_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Model state.
    int mResult = 0;
    int mHi = 0;
    bit mZ = 0, mC = 0, mN = 0, mV = 0, mDone = 0;
    int mBusyLeft = 0;
    int mA = 0, mB = 0;

    function automatic int sgn(input int x);
        return (x >= M / 2) ? x - M : x;
    endfunction

    // Integer-level meaning of each single-cycle opcode.
    function automatic void evalOp(input int op, input int a, input int b, input int cin,
                                   output int r, output bit c, output bit v);
        int full;
        int sv;
        int bw;
        r = 0; c = 0; v = 0; sv = 0;
        bw = 1 - cin;
        case (op)
            0:  begin full = a + b;       r = full % M; c = (full >= M); sv = sgn(a) + sgn(b); end
            1:  begin full = a - b;       r = (full + M) % M; c = (a >= b); sv = sgn(a) - sgn(b); end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = M - 1 - a;
            6:  begin full = a + b + cin; r = full % M; c = (full >= M); sv = sgn(a) + sgn(b) + cin; end
            7:  begin full = a - b - bw;  r = (full + 2 * M) % M; c = (a >= b + bw); sv = sgn(a) - sgn(b) - bw; end
            8:  begin r = (a * 2) % M; c = (a >= M / 2); end
            9:  begin r = a / 2; c = (a % 2 == 1); end
            10: begin r = (a * 2) % M + a / (M / 2); c = (a >= M / 2); end
            11: begin r = a / 2 + (a % 2) * (M / 2); c = (a % 2 == 1); end
            12: begin full = a + 1; r = full % M; c = (full >= M); sv = sgn(a) + 1; end
            13: begin r = (a + M - 1) % M; c = (a == 0); sv = sgn(a) - 1; end
            default: r = a;
        endcase
        v = (sv > M / 2 - 1) || (sv < -(M / 2));
    endfunction

    // Cycle model: what the outputs must look like after each edge.
    always @(posedge clk or negedge reset_n) begin : model
        int r;
        bit c;
        bit v;
        int p;
        if (!reset_n) begin
            mResult <= 0; mHi <= 0; mZ <= 0; mC <= 0; mN <= 0; mV <= 0;
            mDone <= 0; mBusyLeft <= 0;
        end else begin
            mDone <= 0;
            if (mBusyLeft > 0) begin
                if (mBusyLeft == 1) begin
                    p = mA * mB;
                    mResult <= p % M;
                    mHi <= p / M;
                    mZ <= (p == 0);
                    mC <= (p / M != 0);
                    mN <= (p >= M * M / 2);
                    mV <= 0;
                    mDone <= 1;
                end
                mBusyLeft <= mBusyLeft - 1;
            end else if (bus.start) begin
                if (int'(bus.op) == 14) begin
`ifdef ALU_MUL_EN
                    mBusyLeft <= W;
                    mA <= int'(bus.a_in);
                    mB <= int'(bus.b_in);
`else
                    mResult <= 0;
                    mHi <= 0;
                    mDone <= 1;
`endif
                end else begin
                    evalOp(int'(bus.op), int'(bus.a_in), int'(bus.b_in), int'(mC), r, c, v);
                    mResult <= r;
                    mHi <= 0;
                    mZ <= (r == 0);
                    mC <= c;
                    mN <= (r >= M / 2);
                    mV <= v;
                    mDone <= 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("cmp_busy", 32'(bus.busy), 32'(mBusyLeft > 0));
            checkOutput("cmp_done", 32'(bus.done), 32'(mDone));
            checkOutput("cmp_result", 32'(bus.result), 32'(mResult));
            checkOutput("cmp_result_hi", 32'(bus.result_hi), 32'(mHi));
            checkOutput("cmp_flags",
                        32'({bus.zero_flag, bus.carry_flag, bus.negative_flag, bus.overflow_flag}),
                        32'({mZ, mC, mN, mV}));
        end
    end

    // Issue one op, then wait (bounded) until its done pulse is visible.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 3 * W) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: op %0h got no done, expected done within %0d cycles", op, 3 * W);
        end
        #1;
    endtask

    task automatic checkOp(input string name, input logic [7:0] res, input logic [7:0] hi, input logic [3:0] zcnv);
        checkOutput({name, "_result"}, 32'(bus.result), 32'(res));
        checkOutput({name, "_hi"}, 32'(bus.result_hi), 32'(hi));
        checkOutput({name, "_zcnv"},
                    32'({bus.zero_flag, bus.carry_flag, bus.negative_flag, bus.overflow_flag}),
                    32'(zcnv));
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({name, "_done"}, 32'(bus.done), 32'd0);
        checkOp(name, 8'h00, 8'h00, 4'b0000);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        int busyCount;
        int sawDone;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.op    = 4'h0;
        bus.a_in  = 8'h00;
        bus.b_in  = 8'h00;
        #12;
        checkAllZero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        cmpEn   = 1'b1;

        applyStimulus(4'h0, 8'hFF, 8'h01); checkOp("add_ff_01", 8'h00, 8'h00, 4'b1100);
        applyStimulus(4'h6, 8'h01, 8'h01); checkOp("adc_c1",    8'h03, 8'h00, 4'b0000);
        applyStimulus(4'h1, 8'h05, 8'h07); checkOp("sub_05_07", 8'hFE, 8'h00, 4'b0010);
        applyStimulus(4'h7, 8'h10, 8'h01); checkOp("sbc_c0",    8'h0E, 8'h00, 4'b0100);
        applyStimulus(4'h0, 8'h7F, 8'h01); checkOp("add_ovf",   8'h80, 8'h00, 4'b0011);
        applyStimulus(4'h6, 8'h00, 8'h00); checkOp("adc_c0",    8'h00, 8'h00, 4'b1000);
        applyStimulus(4'h8, 8'h81, 8'h00); checkOp("shl_81",    8'h02, 8'h00, 4'b0100);
        applyStimulus(4'hB, 8'h01, 8'h00); checkOp("ror_01",    8'h80, 8'h00, 4'b0110);
        applyStimulus(4'h2, 8'hF0, 8'h3C); checkOp("and",       8'h30, 8'h00, 4'b0000);
        applyStimulus(4'h3, 8'h00, 8'h00); checkOp("or_zero",   8'h00, 8'h00, 4'b1000);
        applyStimulus(4'h4, 8'hAA, 8'h55); checkOp("xor",       8'hFF, 8'h00, 4'b0010);
        applyStimulus(4'h5, 8'h0F, 8'h00); checkOp("not",       8'hF0, 8'h00, 4'b0010);
        applyStimulus(4'h9, 8'h01, 8'h00); checkOp("shr_01",    8'h00, 8'h00, 4'b1100);
        applyStimulus(4'hA, 8'h80, 8'h00); checkOp("rol_80",    8'h01, 8'h00, 4'b0100);
        applyStimulus(4'hC, 8'h7F, 8'h00); checkOp("inc_7f",    8'h80, 8'h00, 4'b0011);
        applyStimulus(4'hD, 8'h00, 8'h00); checkOp("dec_00",    8'hFF, 8'h00, 4'b0110);
        applyStimulus(4'hD, 8'h80, 8'h00); checkOp("dec_80",    8'h7F, 8'h00, 4'b0001);
        applyStimulus(4'hF, 8'h80, 8'h00); checkOp("pass_80",   8'h80, 8'h00, 4'b0010);

        // Back-to-back starts, one per cycle.
        @(negedge clk); bus.start = 1'b1; bus.op = 4'h0; bus.a_in = 8'h01; bus.b_in = 8'h02;
        @(negedge clk); bus.op = 4'h4; bus.a_in = 8'hFF; bus.b_in = 8'h0F;
        @(negedge clk); bus.op = 4'hC; bus.a_in = 8'hFF;
        @(negedge clk); bus.op = 4'h1; bus.a_in = 8'h03; bus.b_in = 8'h03;
        @(negedge clk); bus.start = 1'b0;
        #1;
        checkOutput("b2b_done", 32'(bus.done), 32'd1);
        checkOp("b2b_sub_eq", 8'h00, 8'h00, 4'b1100);

        // Multiply with extra starts attempted while busy.
        applyStimulus(4'hF, 8'h80, 8'h00);
        @(negedge clk); bus.start = 1'b1; bus.op = 4'hE; bus.a_in = 8'h0F; bus.b_in = 8'h11;
        @(negedge clk);
        bus.op = 4'h0; bus.a_in = 8'h01; bus.b_in = 8'h01;
        busyCount = 0;
        for (int i = 0; i < 3 * W && !bus.done; i++) begin
            if (bus.busy) busyCount++;
            if (i == 2) bus.start = 1'b0;
            @(negedge clk);
        end
        bus.start = 1'b0;
        #1;
        checkOutput("mul_done", 32'(bus.done), 32'd1);
`ifdef ALU_MUL_EN
        checkOutput("mul_busy_cycles", 32'(busyCount), 32'(W));
        checkOp("mul_0f_11", 8'hFF, 8'h00, 4'b0000);
`else
        checkOutput("mul_busy_cycles", 32'(busyCount), 32'd0);
        checkOp("mul_disabled", 8'h00, 8'h00, 4'b0010);
`endif

        // Asynchronous reset in the middle of a multiply.
        applyStimulus(4'h1, 8'h05, 8'h07); checkOp("pre_reset_sub", 8'hFE, 8'h00, 4'b0010);
        @(negedge clk); bus.start = 1'b1; bus.op = 4'hE; bus.a_in = 8'h0F; bus.b_in = 8'h11;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkAllZero("mid_reset");
        @(negedge clk); reset_n = 1'b1;
        sawDone = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (bus.done) sawDone++;
        end
        checkOutput("no_done_after_abort", 32'(sawDone), 32'd0);
        applyStimulus(4'h0, 8'h02, 8'h03); checkOp("post_reset_add", 8'h05, 8'h00, 4'b0000);

        @(negedge clk);
        @(negedge clk);
        cmpEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
